sfifo_param: RTL and testbench
==============================

SFIFO_PARAM -- requirements
Module: sfifo_param

Interface
REQ-001 Parameter WIDTH, default 3: data word width in bits, >=1.
REQ-002 Parameter DEPTH, default 8: number of entries, power of two, >=2.
REQ-003 Parameter AF_THRESH, default DEPTH-1: almost_full asserts when count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 1: almost_empty asserts when count <= AE_THRESH.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 wen  input  1  write request.
REQ-008 ren  input  1  read request.
REQ-009 datain  input  WIDTH  write data.
REQ-010 dataout  output  WIDTH  read data.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 almost_full  output  1  threshold flag per REQ-003.
REQ-014 almost_empty  output  1  threshold flag per REQ-004.
REQ-015 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow  output  1  one-cycle pulse, rejected write.
REQ-017 underflow  output  1  one-cycle pulse, rejected read.

Function
REQ-018 Write accepted iff wen && !full; datain stored at write pointer, pointer increments.
REQ-019 Read accepted iff ren && !empty; read pointer increments.
REQ-020 Pointers are clog2(DEPTH)+1 bits; low bits address storage, MSB is wrap bit; wrap from DEPTH-1 to 0 is seamless.
REQ-021 empty when pointers fully equal; full when addresses equal and wrap bits differ.
REQ-022 count = wr_ptr - rd_ptr modulo 2*DEPTH; accepted write alone +1, accepted read alone -1, both accepted unchanged.
REQ-023 Full with wen && ren: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.
REQ-024 Empty with wen && ren: write accepted, read rejected, underflow pulses, count becomes 1.
REQ-025 overflow/underflow registered: high for exactly the cycle after the rejected request; back-to-back rejects give continuous high.
REQ-026 full, empty, almost_full, almost_empty, count are registered or decoded from registered pointers only; no combinational path from wen/ren.
REQ-027 Data order strictly first-in first-out; no entry lost or duplicated across any number of wraps.

Reset
REQ-028 rst high clears both pointers to 0 immediately, regardless of clk.
REQ-029 During and after reset: empty=1, full=0, count=0, almost_empty=1, almost_full=0 (unless AF_THRESH==0), overflow=0, underflow=0, dataout=0.
REQ-030 Storage contents not cleared; unreadable until rewritten.
REQ-031 Reset asserted mid-burst discards all entries; first access after release behaves as from power-up.

Configuration
REQ-032 Macro SFIFO_FWFT_EN selects read mode.
REQ-033 Without SFIFO_FWFT_EN: dataout registered, loaded with head entry on the edge accepting a read (valid the cycle after ren), held otherwise.
REQ-034 With SFIFO_FWFT_EN: dataout continuously presents head entry when !empty (first write visible the cycle after its accept); accepted read advances to next entry; value when empty is don't-care but stable.

Structure
REQ-035 Shared package sfifo_pkg holds default WIDTH/DEPTH constants and the clog2 helper function.
REQ-036 Storage array lives in sub-module sfifo_mem (one synchronous write port, one asynchronous read port, WIDTH x DEPTH); pointer, flag and count logic stays in sfifo_param.

Verification (WIDTH=8, DEPTH=8, AF_THRESH=7, AE_THRESH=1)
REQ-037 Reset, write 0x10..0x17 -> full=1 after 8th accept, count=8, almost_full from count 7; extra write -> overflow pulse, count stays 8.
REQ-038 Read 8 -> dataout sequence 0x10..0x17 (one-cycle latency, or zero with SFIFO_FWFT_EN), empty=1; extra read -> underflow pulse, count 0.
REQ-039 Write 5 / read 5 repeated 4 times -> pointers wrap, data in order, count returns to 0 each pass.
REQ-040 Simultaneous wen/ren at count 4 for 10 cycles -> count stays 4, output order preserved; at full -> REQ-023; at empty -> REQ-024.
REQ-041 Assert rst asynchronously (between edges) at count 5 -> empty=1, count=0, flags cleared immediately; next write 0xAA reads back 0xAA.

Source files
------------

// File: rtl/sfifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Read mode of sfifo_param is selected by the SFIFO_FWFT_EN macro.
package sfifo_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_DEPTH = 8;

  // Ceiling log2 of n; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// WIDTH x DEPTH storage for sfifo_param: one synchronous write port and
// one asynchronous read port. Contents are deliberately never reset.
module sfifo_mem
  import sfifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sfifo_param.sv
// Parameterised synchronous FIFO with wrap-bit pointers, threshold flags and
// overflow/underflow pulses. Define SFIFO_FWFT_EN for first-word-fall-through.
module sfifo_param
  import sfifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wen,
  input  logic                    ren,
  input  logic [WIDTH-1:0]        datain,
  output logic [WIDTH-1:0]        dataout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_data;

  // Status is decoded only from registered pointers, never from wen/ren.
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_comb begin
    wr_acc   = wen && !full;
    rd_acc   = ren && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    ovf_d = wen && full;
    unf_d = ren && empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sfifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (datain),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef SFIFO_FWFT_EN
  // Head entry shown directly; forced to zero while empty so it stays stable.
  assign dataout = empty ? '0 : rd_data;
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = rd_acc ? rd_data : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dataout = dout_q;
`endif

endmodule

// File: tb/tb_sfifo_param.sv
// Self-checking bench for sfifo_param (WIDTH=8, DEPTH=8, AF=7, AE=1),
// covering both the registered and the SFIFO_FWFT_EN read modes.
module tb_sfifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AFT   = 7;
  localparam int AET   = 1;
  localparam int NVEC  = 31;

  typedef struct {
    logic       wen;
    logic       ren;
    logic [7:0] din;
    int         exp_count;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             wen;
  logic             ren;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [3:0]       count;
  logic             overflow;
  logic             underflow;

  int         n_vec;
  int         n_bad;
  int         n_txn;
  logic [7:0] sb[$];
  logic [7:0] last_d;
  vec_t       tbl [NVEC];

  sfifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AFT),
    .AE_THRESH (AET)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wen          (wen),
    .ren          (ren),
    .datain       (datain),
    .dataout      (dataout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h (txn %0d, t=%0t)", name, act, exp, n_txn, $time);
    end
  endtask

  task automatic chk_flags(input int n, input logic ovf, input logic unf);
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AFT));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AET));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("underflow", 32'(underflow), 32'(unf));
  endtask

  // One clock of traffic: scoreboard predicts acceptance from its own occupancy.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    int   n;
    logic wr_ok;
    logic rd_ok;
    @(negedge clk);
    wen    = w;
    ren    = r;
    datain = d;
    n      = sb.size();
    wr_ok  = w && (n < DEPTH);
    rd_ok  = r && (n > 0);
`ifdef SFIFO_FWFT_EN
    #1;
    if (n > 0) chk("fwft_head", 32'(dataout), 32'(sb[0]));
`endif
    if (rd_ok) last_d = sb.pop_front();
    if (wr_ok) sb.push_back(d);
    @(posedge clk);
    #1;
    n_txn = n_txn + 1;
    chk_flags(sb.size(), w && !wr_ok, r && !rd_ok);
`ifndef SFIFO_FWFT_EN
    chk("dataout", 32'(dataout), 32'(last_d));
`endif
    $display("txn %0d wen=%0b ren=%0b din=%02h count=%0d dout=%02h ovf=%0b unf=%0b exp_head=%02h",
             n_txn, w, r, d, count, dataout, overflow, underflow, last_d);
  endtask

  task automatic apply_reset_async();
    @(negedge clk);
    wen = 1'b0;
    ren = 1'b0;
    #2 rst = 1'b1;
    #1;
    sb.delete();
    last_d = 8'h00;
    chk_flags(0, 1'b0, 1'b0);
    chk("rst_dataout", 32'(dataout), 32'h0);
    @(posedge clk);
    #1;
    chk_flags(0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    n_txn  = 0;
    last_d = 8'h00;
    rst    = 1'b1;
    wen    = 1'b0;
    ren    = 1'b0;
    datain = 8'h00;

    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 8'(8'h10 + i), i + 1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h18, 8, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h19, 8, 1'b1, 1'b0};
    for (int i = 10; i < 18; i++) tbl[i] = '{1'b0, 1'b1, 8'h00, 17 - i, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 8'h30, 1, 1'b0, 1'b1};
    for (int i = 22; i < 29; i++) tbl[i] = '{1'b1, 1'b0, 8'(8'h31 + (i - 22)), i - 20, 1'b0, 1'b0};
    tbl[29] = '{1'b1, 1'b1, 8'h38, 7, 1'b1, 1'b0};
    tbl[30] = '{1'b0, 1'b0, 8'h00, 7, 1'b0, 1'b0};

    // Reset is visible before any clock edge.
    #2;
    chk_flags(0, 1'b0, 1'b0);
    chk("rst_dataout", 32'(dataout), 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].wen, tbl[i].ren, tbl[i].din);
      chk("tbl_count", 32'(count), 32'(tbl[i].exp_count));
      chk("tbl_overflow", 32'(overflow), 32'(tbl[i].exp_ovf));
      chk("tbl_underflow", 32'(underflow), 32'(tbl[i].exp_unf));
    end
    while (sb.size() > 0) step(1'b0, 1'b1, 8'h00);

    // Write 5 / read 5, four passes, walks pointers across several wraps.
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'(8'h40 + p * 16 + k));
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'h00);
      chk("pass_count_zero", 32'(count), 32'h0);
    end

    // Simultaneous traffic at steady occupancy 4.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'(8'h80 + k));
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 8'(8'h90 + k));
      chk("steady_count", 32'(count), 32'h4);
    end
    while (sb.size() > 0) step(1'b0, 1'b1, 8'h00);

    // Asynchronous reset mid-burst at occupancy 5, then power-up behaviour.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'(8'hC0 + k));
    apply_reset_async();
    step(1'b1, 1'b0, 8'hAA);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_data", 32'(last_d), 32'hAA);
    step(1'b0, 1'b1, 8'h00);

    // Random traffic mix.
    for (int k = 0; k < 200; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    while (sb.size() > 0) step(1'b0, 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
